// File: rtl/att_serial_receiver_pkg.sv
// rtl/att_serial_receiver_pkg.sv - shared constants, state and error encodings for the attenuator link receiver
package att_serial_pkg;

  localparam int ATT_WIDTH  = 5;
  localparam int FRAME_BITS = ATT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    OVERFLOW = 2'd2
  } rx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_PAD     = 2'd2;
  localparam logic [1:0] ERR_BOTH_LE = 2'd3;

  // Rejection cause with collision outranking length, and length outranking pad.
  function automatic logic [1:0] err_select(input logic both_le, input logic count_bad,
                                            input logic pad_bad);
    if (both_le) return ERR_BOTH_LE;
    if (count_bad) return ERR_COUNT;
    if (pad_bad) return ERR_PAD;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/att_serial_receiver_if.sv
// rtl/att_serial_receiver_if.sv - serial link pins and latched register outputs of the receiver
interface att_serial_if;
  import att_serial_pkg::*;

  logic                 ser_clk;
  logic                 ser_data;
  logic                 ser_le;
  logic                 ser_le_2;
  logic [ATT_WIDTH-1:0] att;
  logic [ATT_WIDTH-1:0] att_2;
  logic                 att_valid;
  logic                 att_2_valid;
  logic                 frame_error;
  logic [1:0]           err_code;

  // Link driver side: drives the pins, observes the latched values.
  modport master (
    output ser_clk, ser_data, ser_le, ser_le_2,
    input  att, att_2, att_valid, att_2_valid, frame_error, err_code
  );

  // Receiver side.
  modport slave (
    input  ser_clk, ser_data, ser_le, ser_le_2,
    output att, att_2, att_valid, att_2_valid, frame_error, err_code
  );
endinterface

// File: rtl/att_serial_receiver_sync_edge_det.sv
// rtl/att_serial_receiver_sync_edge_det.sv - synchroniser, history flop and armed rising-edge detector for one link pin
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic [2:0]             arm_q;
  logic                   armed;

  assign armed = (arm_q == ARM_DONE);

  // Synchronise the pin, keep one cycle of history, and register the edge so the
  // level output (history) and the edge pulse refer to the same sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      arm_q  <= 3'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= armed & sync_q[SYNC_STAGES-1] & ~hist_q;
      if (!armed) begin
        arm_q <= arm_q + 3'd1;
      end
    end
  end

  assign sync_out = hist_q;
  assign rise     = rise_q;

endmodule

// File: rtl/att_serial_receiver.sv
// rtl/att_serial_receiver.sv - oversampling deserialiser for the two-channel attenuator serial link
module att_serial_receiver
  import att_serial_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  att_serial_if.slave  bus
);

  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_rise;
  logic data_s;
  logic le_s, le_rise;
  logic le2_s, le2_rise;
  logic unused_clk_level;
  logic unused_data_rise;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [ATT_WIDTH-1:0]  att_q, att_d;
  logic [ATT_WIDTH-1:0]  att2_q, att2_d;
  logic                  att_valid_q, att_valid_d;
  logic                  att2_valid_q, att2_valid_d;
  logic                  ferr_q, ferr_d;
  logic [1:0]            err_q, err_d;

  logic                  le_any;
  logic                  le_level;
  logic [1:0]            err_sel;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .async_in(bus.ser_clk), .sync_out(unused_clk_level), .rise(clk_rise)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .async_in(bus.ser_data), .sync_out(data_s), .rise(unused_data_rise)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk(clk), .reset(reset), .async_in(bus.ser_le), .sync_out(le_s), .rise(le_rise)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le2 (
    .clk(clk), .reset(reset), .async_in(bus.ser_le_2), .sync_out(le2_s), .rise(le2_rise)
  );

  assign le_any   = le_rise | le2_rise;
  assign le_level = le_s | le2_s;
  assign err_sel  = err_select(le_rise & le2_rise,
                               count_q != CNT_W'(FRAME_BITS),
                               shift_q[0]);

  // Register the frame state, the latched values and the one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      att_q        <= '0;
      att2_q       <= '0;
      att_valid_q  <= 1'b0;
      att2_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      att_q        <= att_d;
      att2_q       <= att2_d;
      att_valid_q  <= att_valid_d;
      att2_valid_q <= att2_valid_d;
      ferr_q       <= ferr_d;
      err_q        <= err_d;
    end
  end

  // Latch events win over a coincident ser_clk edge and are judged on the pre-shift
  // frame; otherwise shift bits in, and abandon a stalled partial frame on timeout.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    att_d        = att_q;
    att2_d       = att2_q;
    att_valid_d  = 1'b0;
    att2_valid_d = 1'b0;
    ferr_d       = 1'b0;
    err_d        = err_q;

    if (le_any) begin
      idle_d  = '0;
      count_d = '0;
      state_d = IDLE;
      if (err_sel != ERR_NONE) begin
        ferr_d = 1'b1;
        err_d  = err_sel;
      end else if (le_rise) begin
        att_d       = shift_q[FRAME_BITS-1:1];
        att_valid_d = 1'b1;
      end else begin
        att2_d       = shift_q[FRAME_BITS-1:1];
        att2_valid_d = 1'b1;
      end
    end else if (clk_rise) begin
      idle_d = '0;
      if (!le_level) begin
        case (state_q)
          IDLE: begin
            shift_d = {shift_q[FRAME_BITS-2:0], data_s};
            count_d = CNT_W'(1);
            state_d = SHIFT;
          end
          SHIFT: begin
            if (count_q == CNT_W'(FRAME_BITS)) begin
              count_d = CNT_W'(FRAME_BITS + 1);
              state_d = OVERFLOW;
            end else begin
              shift_d = {shift_q[FRAME_BITS-2:0], data_s};
              count_d = count_q + 1'b1;
            end
          end
          OVERFLOW: begin
            state_d = OVERFLOW;
          end
          default: begin
            state_d = IDLE;
            count_d = '0;
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d  = '0;
        count_d = '0;
        state_d = IDLE;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign bus.att         = att_q;
  assign bus.att_2       = att2_q;
  assign bus.att_valid   = att_valid_q;
  assign bus.att_2_valid = att2_valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.err_code    = err_q;

endmodule

// File: tb/tb_att_serial_receiver.sv
// tb/tb_att_serial_receiver.sv - directed self-checking bench with a frame-level reference model
module tb_att_serial_receiver;
  import att_serial_pkg::*;

  localparam int TIMEOUT = 1023;

  typedef struct {
    int         at;
    int         kind;   // 1 = att load, 2 = att_2 load, 3 = error
    logic [4:0] val;
    logic [1:0] code;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  att_serial_if bus ();

  att_serial_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  logic bitq[$];
  ev_t  evq[$];
  int   last_edge = 0;
  int   last_le_cyc = 0;
  int   att_pulse_cyc = -1;
  logic [4:0] exp_att = '0;
  logic [4:0] exp_att2 = '0;
  logic [1:0] exp_err = '0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ser_data = b;
    tick(1);
    bus.ser_clk = 1'b1;
    if (cyc - last_edge > TIMEOUT) bitq.delete();
    last_edge = cyc;
    if (bitq.size() <= FRAME_BITS) bitq.push_back(b);
    tick(3);
    bus.ser_clk = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [4:0] v);
    for (int i = 4; i >= 0; i--) send_bit(v[i]);
    send_bit(1'b0);
  endtask

  // which: 1 = ser_le, 2 = ser_le_2, 3 = both together
  task automatic pulse_le(input int which);
    ev_t e;
    e.at   = cyc + 4;
    e.val  = '0;
    e.code = ERR_NONE;
    if (which == 3) begin
      e.kind = 3; e.code = ERR_BOTH_LE;
    end else if (bitq.size() != FRAME_BITS) begin
      e.kind = 3; e.code = ERR_COUNT;
    end else if (bitq[FRAME_BITS-1] != 1'b0) begin
      e.kind = 3; e.code = ERR_PAD;
    end else begin
      e.kind = which;
      for (int i = 0; i < ATT_WIDTH; i++) e.val[ATT_WIDTH-1-i] = bitq[i];
    end
    evq.push_back(e);
    bitq.delete();
    last_edge = cyc;
    last_le_cyc = cyc;
    if (which != 2) bus.ser_le = 1'b1;
    if (which != 1) bus.ser_le_2 = 1'b1;
    tick(3);
    bus.ser_le = 1'b0;
    bus.ser_le_2 = 1'b0;
    tick(3);
  endtask

  // Per-cycle comparison of all outputs against the model.
  initial begin
    logic e_v, e_v2, e_f;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_att = '0; exp_att2 = '0; exp_err = '0;
      end else begin
        e_v = 1'b0; e_v2 = 1'b0; e_f = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          e = evq.pop_front();
          case (e.kind)
            1: begin exp_att = e.val; e_v = 1'b1; end
            2: begin exp_att2 = e.val; e_v2 = 1'b1; end
            default: begin exp_err = e.code; e_f = 1'b1; end
          endcase
        end
        check("att_valid", int'(bus.att_valid), int'(e_v));
        check("att_2_valid", int'(bus.att_2_valid), int'(e_v2));
        check("frame_error", int'(bus.frame_error), int'(e_f));
        check("att", int'(bus.att), int'(exp_att));
        check("att_2", int'(bus.att_2), int'(exp_att2));
        check("err_code", int'(bus.err_code), int'(exp_err));
        if (bus.att_valid) att_pulse_cyc = cyc;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.ser_clk = 1'b0; bus.ser_data = 1'b0; bus.ser_le = 1'b0; bus.ser_le_2 = 1'b0;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(6);
    check("reset_att", int'(bus.att), 0);
    check("reset_err", int'(bus.err_code), 0);

    // MSB-first 1,0,1,1,0 with pad 0
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    pulse_le(1);
    check("t1_att", int'(bus.att), 22);
    check("t1_att_2", int'(bus.att_2), 0);
    check("t1_latency", att_pulse_cyc - last_le_cyc, 4);

    send_frame(5'd17); pulse_le(1);
    send_frame(5'd3);  pulse_le(2);
    check("t2_att", int'(bus.att), 17);
    check("t2_att_2", int'(bus.att_2), 3);

    for (int i = 0; i < 5; i++) send_bit(1);
    pulse_le(1);
    check("t3_short_err", int'(bus.err_code), 1);
    check("t3_short_att", int'(bus.att), 17);
    for (int i = 0; i < 7; i++) send_bit(0);
    pulse_le(1);
    check("t3_long_err", int'(bus.err_code), 1);
    send_frame(5'd12); pulse_le(1);
    check("t3_recover_att", int'(bus.att), 12);

    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0); send_bit(1);
    pulse_le(1);
    check("t4_pad_err", int'(bus.err_code), 2);
    check("t4_pad_att", int'(bus.att), 12);

    send_frame(5'd21); pulse_le(3);
    check("t5_both_err", int'(bus.err_code), 3);
    check("t5_both_att", int'(bus.att), 12);
    check("t5_both_att_2", int'(bus.att_2), 3);

    send_bit(1); send_bit(1); send_bit(1);
    tick(1100);
    send_frame(5'd9); pulse_le(1);
    check("t6_timeout_att", int'(bus.att), 9);
    check("t6_timeout_err", int'(bus.err_code), 3);

    send_bit(1); send_bit(0); send_bit(1);
    bus.ser_clk = 1'b1;
    reset = 1'b1;
    bitq.delete();
    tick(3);
    reset = 1'b0;
    tick(10);
    bus.ser_clk = 1'b0;
    tick(3);
    check("t7_reset_att", int'(bus.att), 0);
    check("t7_reset_att_2", int'(bus.att_2), 0);
    check("t7_reset_err", int'(bus.err_code), 0);
    send_frame(5'd6); pulse_le(2);
    check("t7_after_att_2", int'(bus.att_2), 6);
    check("t7_after_att", int'(bus.att), 0);

    tick(10);
    check("events_drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/att_serial_receiver.md
Name: att_serial_receiver

Overview:
- Receive side of the 3-wire attenuator serial link (CLK/DATA/LE, plus a second latch LE_2).
- Oversamples the link in the fast FPGA clock domain and deserialises 6-bit MSB-first frames: 5-bit attenuation value followed by a 0 pad bit.
- Presents the latched values as parallel registers for the two channels.
- Used on the companion board/CPLD side, and as the loop-back checker for the attenuator driver.

Parameters:
- ATT_WIDTH, 5, attenuation value width.
- FRAME_BITS, 6, bits per frame (ATT_WIDTH value bits + 1 pad bit).
- SYNC_STAGES, 2, synchroniser flops per serial input; legal range 2..4.
- TIMEOUT_CYCLES, 1023, idle clk cycles after which a partial frame is discarded.

Ports:
- clk  in  1  fabric clock; must be ≥4x the serial clock rate (e.g. 122.88 MHz vs ≤10 MHz link).
- reset  in  1  synchronous, active-high reset.
- ser_clk  in  1  serial clock from link, asynchronous.
- ser_data  in  1  serial data, valid at ser_clk rising edge.
- ser_le  in  1  latch strobe, channel 1.
- ser_le_2  in  1  latch strobe, channel 2.
- att  out  ATT_WIDTH  latched channel-1 value.
- att_2  out  ATT_WIDTH  latched channel-2 value.
- att_valid  out  1  one-cycle pulse when att is updated.
- att_2_valid  out  1  one-cycle pulse when att_2 is updated.
- frame_error  out  1  one-cycle pulse on a rejected latch.
- err_code  out  2  cause of the last error, held until the next error: 1 = bit count ≠ FRAME_BITS, 2 = pad bit nonzero, 3 = both LEs rose together.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high. All logic runs on the rising edge of clk.
- Reset values: att=0, att_2=0, both valids 0, frame_error=0, err_code=0, shift register 0, bit count 0, synchroniser and history flops 0, idle counter 0.
- Arming after reset: the arm counter blocks edge recognition for SYNC_STAGES+1 cycles after reset deasserts. A line that is already high when reset exits is therefore never taken as an edge.
- Input conditioning:
  - Each serial input passes through SYNC_STAGES flops, then a history flop.
  - A rising edge is asserted when the synced value is 1 and the history value is 0.
  - ser_data uses the same depth so it stays aligned with ser_clk.
- States: IDLE, SHIFT, OVERFLOW.
  - IDLE: bit count is 0. A ser_clk rising edge shifts data into LSB (shift <= {shift[FRAME_BITS-2:0], data}), count becomes 1, state goes to SHIFT.
  - SHIFT: each ser_clk rising edge shifts and increments the count. If an edge arrives with count == FRAME_BITS, state goes to OVERFLOW and the count saturates at FRAME_BITS+1.
  - OVERFLOW: ser_clk edges are ignored until a latch event or timeout.
- Latch event: a rising edge on ser_le or ser_le_2, in any state.
  - Accept when count == FRAME_BITS and shift[0] == 0. The target register loads shift[FRAME_BITS-1:1] and its valid pulses for one cycle.
  - Otherwise frame_error pulses, err_code is set, and both outputs are unchanged. Error priority: code 3 over code 1 over code 2.
  - Both LE edges in the same cycle: error 3, neither output updates.
  - After any latch event, accepted or rejected: count=0, state=IDLE, shift register retained (don't-care).
- Same-cycle ser_clk and LE edges: the latch is evaluated on the pre-shift contents and count, and the ser_clk edge is discarded.
- ser_clk edges while a synced LE is high are ignored.
- Latency: att/att_2 and the valid pulse update on the (SYNC_STAGES+2)th clk edge after the first clk edge that samples the LE pin high. For SYNC_STAGES=2 this is 4 cycles.
- Timeout: the idle counter resets on any ser_clk or LE edge and otherwise increments in SHIFT/OVERFLOW. When it reaches TIMEOUT_CYCLES: count=0, state=IDLE, no error pulse. The counter does not run in IDLE.
- Reset mid-frame: a partial frame is discarded and the outputs return to 0.

Decomposition:
- Package att_serial_pkg holds:
  - ATT_WIDTH and FRAME_BITS constants.
  - Receiver state enum (IDLE/SHIFT/OVERFLOW).
  - err_code constants (ERR_NONE=0, ERR_COUNT=1, ERR_PAD=2, ERR_BOTH_LE=3).
- Sub-module sync_edge_det, parameter SYNC_STAGES, ports clk/reset/async_in/sync_out/rise. Instantiated four times (ser_clk, ser_data, ser_le, ser_le_2); rise is unused for data.

Test Plan:
- Send 6 bits 1,0,1,1,0,0 then an ser_le pulse -> att=5'b10110, att_valid one pulse 4 cycles after LE sampled high, att_2 stays 0, no error.
- Send att=17 (100010) + ser_le, then att_2=3 (000110) + ser_le_2 -> att=17, att_2=3, each valid pulses once.
- Send 5 bits then ser_le -> frame_error, err_code=1, att unchanged. Then send 7 bits + ser_le -> err_code=1 again. Then a correct frame is accepted.
- Send pad bit 1 (101101) + ser_le -> frame_error, err_code=2, att unchanged.
- Send a valid frame then raise ser_le and ser_le_2 in the same clk cycle -> err_code=3, neither output updates.
- Send 3 bits, stay idle for 1100 cycles, then a full valid frame with value 9 + ser_le -> att=9, no error. Separately, assert reset mid-frame and also hold ser_clk high across reset release -> outputs 0 and no spurious bit counted.
